// File: rtl/tank_game_pkg.sv
// Shared types and constants for the tank game bullet logic.
package tank_game_pkg;

    localparam int unsigned COORD_W = 10;

    typedef enum logic {
        OWNER_L = 1'b0,
        OWNER_R = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        LOAD
    } arb_state_e;

endpackage

// File: rtl/fire_cooldown_ctr.sv
// Per-player fire cooldown: reloads to COOLDOWN_FRAMES, counts frames down to 0.
// COOLDOWN_FRAMES must be at least 1.
module fire_cooldown_ctr #(
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic Clk,
    input  logic Reset,
    input  logic reload,
    input  logic frame_tick,
    output logic active
);

    localparam int unsigned CW = $clog2(COOLDOWN_FRAMES + 1);

    logic [CW-1:0] cnt_q;

    // Reload wins over a same-cycle frame tick; the count saturates at zero.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cnt_q <= '0;
        end else if (reload) begin
            cnt_q <= CW'(COOLDOWN_FRAMES);
        end else if (frame_tick && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign active = (cnt_q != '0);

endmodule

// File: rtl/bullet_fire_arbiter.sv
// Arbitrates left/right turret fire requests onto the shared bullet slots.
// Applies per-player cooldown and live-bullet cap, round-robin on ties, and
// loads a snapshot of the winner's launch position/motion over valid/ready.
// Optional auto-fire: define BULLET_AUTOFIRE_EN to let a held fire key re-arm
// the request when that player's cooldown expires.
module bullet_fire_arbiter
    import tank_game_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = 4,
    parameter int unsigned COOLDOWN_FRAMES = 30,
    parameter int unsigned MAX_PER_PLAYER  = 2,
    localparam int unsigned SLOT_W         = $clog2(NUM_SLOTS)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_tick,
    input  logic                 fire_req_l,
    input  logic                 fire_req_r,
    input  logic [COORD_W-1:0]   l_pos_x,
    input  logic [COORD_W-1:0]   l_pos_y,
    input  logic [COORD_W-1:0]   l_motion_x,
    input  logic [COORD_W-1:0]   l_motion_y,
    input  logic [COORD_W-1:0]   r_pos_x,
    input  logic [COORD_W-1:0]   r_pos_y,
    input  logic [COORD_W-1:0]   r_motion_x,
    input  logic [COORD_W-1:0]   r_motion_y,
    input  logic [NUM_SLOTS-1:0] slot_retire,
    input  logic                 load_ready,
    output logic                 load_valid,
    output logic [SLOT_W-1:0]    load_slot,
    output logic                 load_owner,
    output logic [COORD_W-1:0]   load_pos_x,
    output logic [COORD_W-1:0]   load_pos_y,
    output logic [COORD_W-1:0]   load_motion_x,
    output logic [COORD_W-1:0]   load_motion_y,
    output logic [NUM_SLOTS-1:0] slot_busy,
    output logic                 cooldown_l,
    output logic                 cooldown_r
);

    localparam int unsigned CNT_W = $clog2(MAX_PER_PLAYER + 1);

    arb_state_e          state_q;
    logic                rr_favour_r_q;   // 1: right wins the next tie
    logic                fire_l_q, fire_r_q;
    logic                pending_l_q, pending_r_q;
    logic [CNT_W-1:0]    count_l_q, count_r_q;
    logic [NUM_SLOTS-1:0] slot_owner_q;   // 1: slot belongs to right player

    logic                handshake;
    logic                any_free;
    logic                elig_l, elig_r;
    logic                win_r;
    owner_e              win_owner;
    logic [SLOT_W-1:0]   free_idx;
    logic [NUM_SLOTS-1:0] ret_hit;
    int unsigned         dec_l, dec_r;
    logic                auto_l, auto_r;

    logic                pending_l_d, pending_r_d;
    logic [CNT_W-1:0]    count_l_d, count_r_d;
    logic [NUM_SLOTS-1:0] busy_d, slot_owner_d;

    fire_cooldown_ctr #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_cooldown_l (
        .Clk        (Clk),
        .Reset      (Reset),
        .reload     (handshake && (load_owner == OWNER_L)),
        .frame_tick (frame_tick),
        .active     (cooldown_l)
    );

    fire_cooldown_ctr #(
        .COOLDOWN_FRAMES (COOLDOWN_FRAMES)
    ) u_cooldown_r (
        .Clk        (Clk),
        .Reset      (Reset),
        .reload     (handshake && (load_owner == OWNER_R)),
        .frame_tick (frame_tick),
        .active     (cooldown_r)
    );

`ifdef BULLET_AUTOFIRE_EN
    logic cd_l_prev_q, cd_r_prev_q;

    // Remember last cycle's cooldown so its expiry can re-arm a held key.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            cd_l_prev_q <= 1'b0;
            cd_r_prev_q <= 1'b0;
        end else begin
            cd_l_prev_q <= cooldown_l;
            cd_r_prev_q <= cooldown_r;
        end
    end

    assign auto_l = fire_req_l && cd_l_prev_q && !cooldown_l;
    assign auto_r = fire_req_r && cd_r_prev_q && !cooldown_r;
`else
    assign auto_l = 1'b0;
    assign auto_r = 1'b0;
`endif

    assign handshake = (state_q == LOAD) && load_ready;
    assign any_free  = |(~slot_busy);
    assign elig_l    = pending_l_q && !cooldown_l &&
                       (count_l_q < CNT_W'(MAX_PER_PLAYER)) && any_free;
    assign elig_r    = pending_r_q && !cooldown_r &&
                       (count_r_q < CNT_W'(MAX_PER_PLAYER)) && any_free;
    assign win_r     = elig_r && (!elig_l || rr_favour_r_q);
    assign win_owner = win_r ? OWNER_R : OWNER_L;
    assign ret_hit   = slot_retire & slot_busy;

    // Lowest-index free slot and per-owner retire tallies.
    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_busy[i]) free_idx = SLOT_W'(i);
        end
        dec_l = 0;
        dec_r = 0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (ret_hit[i]) begin
                if (slot_owner_q[i]) dec_r++;
                else                 dec_l++;
            end
        end
    end

    // Next-state for pending flags, slot occupancy and per-player counts.
    always_comb begin
        pending_l_d = pending_l_q;
        pending_r_d = pending_r_q;
        if ((fire_req_l && !fire_l_q && !cooldown_l) || auto_l) pending_l_d = 1'b1;
        if ((fire_req_r && !fire_r_q && !cooldown_r) || auto_r) pending_r_d = 1'b1;

        busy_d       = slot_busy & ~ret_hit;
        slot_owner_d = slot_owner_q;
        count_l_d    = CNT_W'(32'(count_l_q) - dec_l);
        count_r_d    = CNT_W'(32'(count_r_q) - dec_r);

        if (handshake) begin
            busy_d[load_slot]       = 1'b1;
            slot_owner_d[load_slot] = load_owner;
            if (load_owner == OWNER_R) begin
                pending_r_d = 1'b0;
                count_r_d   = CNT_W'(32'(count_r_q) + 1 - dec_r);
            end else begin
                pending_l_d = 1'b0;
                count_l_d   = CNT_W'(32'(count_l_q) + 1 - dec_l);
            end
        end
    end

    // Bookkeeping registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            fire_l_q     <= 1'b0;
            fire_r_q     <= 1'b0;
            pending_l_q  <= 1'b0;
            pending_r_q  <= 1'b0;
            count_l_q    <= '0;
            count_r_q    <= '0;
            slot_busy    <= '0;
            slot_owner_q <= '0;
        end else begin
            fire_l_q     <= fire_req_l;
            fire_r_q     <= fire_req_r;
            pending_l_q  <= pending_l_d;
            pending_r_q  <= pending_r_d;
            count_l_q    <= count_l_d;
            count_r_q    <= count_r_d;
            slot_busy    <= busy_d;
            slot_owner_q <= slot_owner_d;
        end
    end

    // Grant FSM with registered load payload, held stable until accepted.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= IDLE;
            rr_favour_r_q <= 1'b0;
            load_valid    <= 1'b0;
            load_slot     <= '0;
            load_owner    <= 1'b0;
            load_pos_x    <= '0;
            load_pos_y    <= '0;
            load_motion_x <= '0;
            load_motion_y <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (elig_l || elig_r) state_q <= GRANT;
                end
                GRANT: begin
                    if (elig_l || elig_r) begin
                        load_valid    <= 1'b1;
                        load_slot     <= free_idx;
                        load_owner    <= win_owner;
                        load_pos_x    <= win_r ? r_pos_x    : l_pos_x;
                        load_pos_y    <= win_r ? r_pos_y    : l_pos_y;
                        load_motion_x <= win_r ? r_motion_x : l_motion_x;
                        load_motion_y <= win_r ? r_motion_y : l_motion_y;
                        state_q       <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    if (load_ready) begin
                        load_valid    <= 1'b0;
                        rr_favour_r_q <= (load_owner == OWNER_L);
                        state_q       <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_fire_arbiter.sv
// Directed bench for bullet_fire_arbiter with a load-transaction scoreboard.
module tb_bullet_fire_arbiter;
    import tank_game_pkg::*;

    localparam int unsigned NS = 4;
    localparam int unsigned CD = 3;
    localparam int unsigned MP = 2;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          frame_tick = 1'b0;
    logic          fire_req_l = 1'b0, fire_req_r = 1'b0;
    logic [9:0]    l_pos_x = '0, l_pos_y = '0, l_motion_x = '0, l_motion_y = '0;
    logic [9:0]    r_pos_x = '0, r_pos_y = '0, r_motion_x = '0, r_motion_y = '0;
    logic [NS-1:0] slot_retire = '0;
    logic          load_ready = 1'b1;
    logic          load_valid;
    logic [1:0]    load_slot;
    logic          load_owner;
    logic [9:0]    load_pos_x, load_pos_y, load_motion_x, load_motion_y;
    logic [NS-1:0] slot_busy;
    logic          cooldown_l, cooldown_r;

    bullet_fire_arbiter #(
        .NUM_SLOTS       (NS),
        .COOLDOWN_FRAMES (CD),
        .MAX_PER_PLAYER  (MP)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .frame_tick    (frame_tick),
        .fire_req_l    (fire_req_l),
        .fire_req_r    (fire_req_r),
        .l_pos_x       (l_pos_x),
        .l_pos_y       (l_pos_y),
        .l_motion_x    (l_motion_x),
        .l_motion_y    (l_motion_y),
        .r_pos_x       (r_pos_x),
        .r_pos_y       (r_pos_y),
        .r_motion_x    (r_motion_x),
        .r_motion_y    (r_motion_y),
        .slot_retire   (slot_retire),
        .load_ready    (load_ready),
        .load_valid    (load_valid),
        .load_slot     (load_slot),
        .load_owner    (load_owner),
        .load_pos_x    (load_pos_x),
        .load_pos_y    (load_pos_y),
        .load_motion_x (load_motion_x),
        .load_motion_y (load_motion_y),
        .slot_busy     (slot_busy),
        .cooldown_l    (cooldown_l),
        .cooldown_r    (cooldown_r)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [1:0] slot;
        logic       owner;
        logic [9:0] px, py, mx, my;
    } load_t;

    load_t exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        fire_req_l = 1'b0;
        fire_req_r = 1'b0;
        frame_tick = 1'b0;
        slot_retire = '0;
        ticks(2);
        Reset = 1'b1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    task automatic press_l();
        fire_req_l = 1'b1;
        tick();
        fire_req_l = 1'b0;
        tick();
    endtask

    // Fire edges for the chosen players, then allow enough cycles for two loads.
    task automatic fire(input logic fl, input logic fr);
        fire_req_l = fl;
        fire_req_r = fr;
        tick();
        fire_req_l = 1'b0;
        fire_req_r = 1'b0;
        ticks(8);
    endtask

    task automatic push(input logic [1:0] s, input logic own);
        load_t e;
        e.slot  = s;
        e.owner = own;
        if (own) {e.px, e.py, e.mx, e.my} = {r_pos_x, r_pos_y, r_motion_x, r_motion_y};
        else     {e.px, e.py, e.mx, e.my} = {l_pos_x, l_pos_y, l_motion_x, l_motion_y};
        exp_q.push_back(e);
    endtask

    task automatic retire(input logic [NS-1:0] m);
        slot_retire = m;
        tick();
        slot_retire = '0;
    endtask

    // Scoreboard: every accepted load must match the oldest expected entry.
    always @(negedge Clk) begin
        if (Reset && load_valid && load_ready) begin
            load_t e;
            n_checks++;
            assert (exp_q.size() != 0) n_pass++;
            else $error("FAIL sb_unexpected_load: observed slot %0d owner %0d, expected none",
                        load_slot, load_owner);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("load_xact",
                      64'({load_slot, load_owner, load_pos_x, load_pos_y,
                           load_motion_x, load_motion_y}),
                      64'(e));
            end
        end
    end

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", load_valid, 0);
        check("rst_busy", slot_busy, 0);
        check("rst_cd_l", cooldown_l, 0);
        check("rst_cd_r", cooldown_r, 0);
        check("rst_slot", load_slot, 0);

        // 1: single left shot, latency and payload
        {l_pos_x, l_pos_y, l_motion_x, l_motion_y} = {10'd100, 10'd200, 10'd3, 10'h3FB};
        {r_pos_x, r_pos_y, r_motion_x, r_motion_y} = {10'd500, 10'd50, 10'h3FE, 10'd7};
        push(2'd0, 1'b0);
        fire_req_l = 1'b1;
        tick();
        check("t1_lat0", load_valid, 0);
        tick();
        check("t1_lat1", load_valid, 0);
        tick();
        check("t1_valid", load_valid, 1);
        check("t1_slot", load_slot, 0);
        check("t1_owner", load_owner, 0);
        check("t1_pos_x", load_pos_x, 100);
        check("t1_mot_y", load_motion_y, 10'h3FB);
        tick();
        fire_req_l = 1'b0;
        check("t1_busy", slot_busy, 4'b0001);
        check("t1_cd_l", cooldown_l, 1);
        check("t1_cd_r", cooldown_r, 0);
        check("t1_valid_drop", load_valid, 0);

        // 2: simultaneous requests, left first then right; next tie left again
        do_reset();
        push(2'd0, 1'b0);
        push(2'd1, 1'b1);
        fire(1'b1, 1'b1);
        check("t2_busy1", slot_busy, 4'b0011);
        frames(3);
        check("t2_cd_l_clear", cooldown_l, 0);
        push(2'd2, 1'b0);
        push(2'd3, 1'b1);
        fire(1'b1, 1'b1);
        check("t2_busy2", slot_busy, 4'b1111);

        // 3: edges during cooldown are dropped
        do_reset();
        push(2'd0, 1'b0);
        fire(1'b1, 1'b0);
        check("t3_cd_on", cooldown_l, 1);
        press_l();
        frames(1);
        press_l();
        frames(1);
        press_l();
        frames(1);
        check("t3_cd_off", cooldown_l, 0);
        ticks(4);
        check("t3_no_load", load_valid, 0);
        check("t3_busy_a", slot_busy, 4'b0001);
        push(2'd1, 1'b0);
        fire(1'b1, 1'b0);
        check("t3_busy_b", slot_busy, 4'b0011);

        // 4: per-player cap, retire unblocks within 2 cycles
        frames(3);
        press_l();
        ticks(5);
        check("t4_capped", load_valid, 0);
        check("t4_busy_a", slot_busy, 4'b0011);
        push(2'd0, 1'b0);
        retire(4'b0001);
        check("t4_retired", slot_busy, 4'b0010);
        ticks(2);
        check("t4_valid", load_valid, 1);
        check("t4_slot", load_slot, 0);
        tick();
        check("t4_busy_b", slot_busy, 4'b0011);

        // 5: payload held while stalled; reset aborts LOAD
        do_reset();
        load_ready = 1'b0;
        {l_pos_x, l_pos_y, l_motion_x, l_motion_y} = {10'd10, 10'd20, 10'd1, 10'd2};
        fire_req_l = 1'b1;
        tick();
        fire_req_l = 1'b0;
        ticks(2);
        check("t5_valid", load_valid, 1);
        for (int i = 0; i < 5; i++) begin
            l_pos_x = 10'(100 + i);
            tick();
            check("t5_hold_valid", load_valid, 1);
            check("t5_hold_pos", load_pos_x, 10);
        end
        Reset = 1'b0;
        tick();
        check("t5_rst_valid", load_valid, 0);
        check("t5_rst_busy", slot_busy, 0);
        Reset = 1'b1;
        load_ready = 1'b1;
        ticks(4);
        check("t5_no_resume", load_valid, 0);

        // 6: all slots busy, retire reuses slot 2, idle retire ignored
        do_reset();
        push(2'd0, 1'b0);
        fire(1'b1, 1'b0);
        frames(3);
        push(2'd1, 1'b1);
        push(2'd2, 1'b0);
        fire(1'b1, 1'b1);
        frames(3);
        push(2'd3, 1'b1);
        fire(1'b0, 1'b1);
        frames(3);
        check("t6_full", slot_busy, 4'b1111);
        press_l();
        ticks(5);
        check("t6_no_grant", load_valid, 0);
        push(2'd2, 1'b0);
        retire(4'b0100);
        check("t6_ret2", slot_busy, 4'b1011);
        ticks(2);
        check("t6_valid", load_valid, 1);
        check("t6_slot2", load_slot, 2);
        tick();
        check("t6_refull", slot_busy, 4'b1111);
        frames(3);
        retire(4'b0001);
        check("t6_ret0", slot_busy, 4'b1110);
        retire(4'b0001);
        check("t6_ret_idle", slot_busy, 4'b1110);
        push(2'd0, 1'b0);
        fire(1'b1, 1'b0);
        check("t6_reload0", slot_busy, 4'b1111);
        frames(3);
        fire(1'b1, 1'b0);
        retire(4'b0010);
        ticks(5);
        check("t6_cap_held", load_valid, 0);
        check("t6_final_busy", slot_busy, 4'b1101);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
